// File: rtl/spi_pkg.sv
// Shared definitions for the multi-target SPI controller: FSM encoding,
// chip-select index width helper and the divider clamp constant.
package spi_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LEAD,
      ST_SHIFT,
      ST_TRAIL,
      ST_GAP,
      ST_RESP
   } spi_state_e;

   // A programmed divider of 0 behaves exactly like this value.
   localparam int DIV_MIN = 1;

   function automatic int cs_width(input int num_cs);
      return (num_cs <= 1) ? 1 : $clog2(num_cs);
   endfunction

endpackage

// File: rtl/spi_clock_gen.sv
// SCLK half-period generator: after start it emits 2*DATA_WIDTH edges spaced
// D clocks apart (the first D clocks after start), then one D-clock trail.
module spi_clock_gen #(
   parameter int DIVIDER_WIDTH = 8,
   parameter int NUM_EDGES     = 64
) (
   input  logic                     clock,
   input  logic                     reset_n,
   input  logic                     start,
   input  logic [DIVIDER_WIDTH-1:0] divider,
   input  logic                     cpol,
   output logic                     sclk,
   output logic                     lead_edge,
   output logic                     trail_edge,
   output logic                     last_edge,
   output logic                     done
);

   localparam int EW = $clog2(NUM_EDGES + 1);

   logic                     active_q;
   logic                     trail_q;
   logic                     cpol_q;
   logic                     sclk_q;
   logic [DIVIDER_WIDTH-1:0] div_q;
   logic [DIVIDER_WIDTH-1:0] cnt_q;
   logic [EW-1:0]            edges_q;
   logic                     tick;

   // Edge pulses are asserted in the cycle before the SCLK change becomes visible.
   assign tick       = active_q && (cnt_q == '0);
   assign lead_edge  = tick && !trail_q && (sclk_q == cpol_q);
   assign trail_edge = tick && !trail_q && (sclk_q != cpol_q);
   assign last_edge  = tick && !trail_q && (edges_q == EW'(1));
   assign done       = tick && trail_q;
   assign sclk       = sclk_q;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         active_q <= 1'b0;
         trail_q  <= 1'b0;
         cpol_q   <= 1'b0;
         sclk_q   <= 1'b0;
         div_q    <= '0;
         cnt_q    <= '0;
         edges_q  <= '0;
      end else if (start) begin
         active_q <= 1'b1;
         trail_q  <= 1'b0;
         cpol_q   <= cpol;
         sclk_q   <= cpol;
         div_q    <= divider;
         cnt_q    <= divider - DIVIDER_WIDTH'(1);
         edges_q  <= EW'(NUM_EDGES);
      end else if (active_q) begin
         if (cnt_q != '0) begin
            cnt_q <= cnt_q - DIVIDER_WIDTH'(1);
         end else begin
            cnt_q <= div_q - DIVIDER_WIDTH'(1);
            if (trail_q) begin
               active_q <= 1'b0;
            end else begin
               sclk_q  <= ~sclk_q;
               edges_q <= edges_q - EW'(1);
               if (edges_q == EW'(1)) trail_q <= 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/spi_multi_controller.sv
// Command/response SPI master driving one of NUM_CS chip selects per frame,
// with per-command clock mode and SCLK divider.
module spi_multi_controller
   import spi_pkg::*;
#(
   parameter int  NUM_CS        = 4,
   parameter int  DATA_WIDTH    = 32,
   parameter int  DIVIDER_WIDTH = 8,
   parameter int  GAP_CYCLES    = 2,
   localparam int CSW           = cs_width(NUM_CS)
) (
   input  logic                     i_clock,
   input  logic                     i_reset_n,
   input  logic                     i_cmd_valid,
   output logic                     o_cmd_ready,
   input  logic [CSW-1:0]           i_cmd_cs,
   input  logic                     i_cmd_cpol,
   input  logic                     i_cmd_cpha,
   input  logic [DIVIDER_WIDTH-1:0] i_cmd_divider,
   input  logic [DATA_WIDTH-1:0]    i_cmd_data,
   output logic                     o_rsp_valid,
   input  logic                     i_rsp_ready,
   output logic [DATA_WIDTH-1:0]    o_rsp_data,
   output logic                     o_rsp_err,
   output logic                     o_busy,
   output logic [NUM_CS-1:0]        o_spi_cs_n,
   output logic                     o_spi_clock,
   output logic                     o_spi_mosi,
   input  logic                     i_spi_miso
);

   localparam int GW = $clog2(GAP_CYCLES + 1);

   spi_state_e               state_q, state_d;
   logic                     armed_q;
   logic [CSW-1:0]           cs_q;
   logic                     cpha_q;
   logic                     err_q;
   logic [DATA_WIDTH-1:0]    tx_q;
   logic [DATA_WIDTH-1:0]    rx_q;
   logic                     mosi_q;
   logic [GW-1:0]            gap_q;
   logic [DIVIDER_WIDTH-1:0] div_eff;
   logic                     cmd_fire, cs_oob, frame_active;
   logic                     lead_edge, trail_edge, last_edge, done;
   logic                     shift_evt, sample_evt;

   assign o_cmd_ready  = armed_q && (state_q == ST_IDLE);
   assign cmd_fire     = i_cmd_valid && o_cmd_ready;
   assign cs_oob       = int'(i_cmd_cs) >= NUM_CS;
   assign div_eff      = (i_cmd_divider == '0) ? DIVIDER_WIDTH'(DIV_MIN) : i_cmd_divider;
   assign frame_active = (state_q == ST_LEAD) || (state_q == ST_SHIFT) || (state_q == ST_TRAIL);
   assign o_busy       = (state_q != ST_IDLE);
   assign o_rsp_valid  = (state_q == ST_RESP);
   assign o_rsp_data   = rx_q;
   assign o_rsp_err    = err_q;
   assign o_spi_mosi   = mosi_q;

   // cpha=0 presents the MSB at CS fall and advances on trailing edges (except the last);
   // cpha=1 advances on leading edges and samples on trailing ones.
   assign shift_evt  = cpha_q ? lead_edge : (trail_edge && !last_edge);
   assign sample_evt = cpha_q ? trail_edge : lead_edge;

   spi_clock_gen #(
      .DIVIDER_WIDTH (DIVIDER_WIDTH),
      .NUM_EDGES     (2 * DATA_WIDTH)
   ) u_clock_gen (
      .clock      (i_clock),
      .reset_n    (i_reset_n),
      .start      (cmd_fire),
      .divider    (div_eff),
      .cpol       (i_cmd_cpol),
      .sclk       (o_spi_clock),
      .lead_edge  (lead_edge),
      .trail_edge (trail_edge),
      .last_edge  (last_edge),
      .done       (done)
   );

   always_comb begin
      o_spi_cs_n = '1;
      if (frame_active && !err_q) begin
         for (int i = 0; i < NUM_CS; i++) begin
            if (cs_q == CSW'(i)) o_spi_cs_n[i] = 1'b0;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (cmd_fire)      state_d = ST_LEAD;
         ST_LEAD:  if (lead_edge)     state_d = ST_SHIFT;
         ST_SHIFT: if (last_edge)     state_d = ST_TRAIL;
         ST_TRAIL: if (done)          state_d = ST_GAP;
         ST_GAP:   if (gap_q == '0)   state_d = ST_RESP;
         ST_RESP:  if (i_rsp_ready)   state_d = ST_IDLE;
         default:                     state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state_q <= ST_IDLE;
         armed_q <= 1'b0;
         cs_q    <= '0;
         cpha_q  <= 1'b0;
         err_q   <= 1'b0;
         tx_q    <= '0;
         rx_q    <= '0;
         mosi_q  <= 1'b0;
         gap_q   <= '0;
      end else begin
         state_q <= state_d;
         armed_q <= 1'b1;
         if (cmd_fire) begin
            cs_q   <= i_cmd_cs;
            cpha_q <= i_cmd_cpha;
            err_q  <= cs_oob;
            tx_q   <= i_cmd_cpha ? i_cmd_data : {i_cmd_data[DATA_WIDTH-2:0], 1'b0};
            mosi_q <= i_cmd_cpha ? 1'b0 : i_cmd_data[DATA_WIDTH-1];
         end else begin
            if (shift_evt) begin
               mosi_q <= tx_q[DATA_WIDTH-1];
               tx_q   <= {tx_q[DATA_WIDTH-2:0], 1'b0};
            end
            if (sample_evt) rx_q <= {rx_q[DATA_WIDTH-2:0], i_spi_miso};
            if (done) gap_q <= GW'(GAP_CYCLES - 1);
            else if (state_q == ST_GAP && gap_q != '0) gap_q <= gap_q - GW'(1);
            if (state_q == ST_RESP && i_rsp_ready) mosi_q <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_spi_multi_controller.sv
// Scoreboard bench for spi_multi_controller: directed frames, a mode-aware
// slave model and a waveform monitor measuring CS/SCLK timing per frame.
module tb_spi_multi_controller;

   localparam int NUM_CS = 3;
   localparam int DW     = 8;
   localparam int DIVW   = 8;
   localparam int GAP    = 2;

   logic            clk = 1'b0;
   logic            rst_n = 1'b1;
   logic            cmd_valid = 1'b0;
   logic            cmd_ready;
   logic [1:0]      cmd_cs = '0;
   logic            cmd_cpol = 1'b0;
   logic            cmd_cpha = 1'b0;
   logic [DIVW-1:0] cmd_div = '0;
   logic [DW-1:0]   cmd_data = '0;
   logic            rsp_valid;
   logic            rsp_ready = 1'b1;
   logic [DW-1:0]   rsp_data;
   logic            rsp_err;
   logic            busy;
   logic [NUM_CS-1:0] cs_n;
   logic            sclk, mosi, miso;

   always #5 clk = ~clk;

   spi_multi_controller #(
      .NUM_CS        (NUM_CS),
      .DATA_WIDTH    (DW),
      .DIVIDER_WIDTH (DIVW),
      .GAP_CYCLES    (GAP)
   ) dut (
      .i_clock       (clk),
      .i_reset_n     (rst_n),
      .i_cmd_valid   (cmd_valid),
      .o_cmd_ready   (cmd_ready),
      .i_cmd_cs      (cmd_cs),
      .i_cmd_cpol    (cmd_cpol),
      .i_cmd_cpha    (cmd_cpha),
      .i_cmd_divider (cmd_div),
      .i_cmd_data    (cmd_data),
      .o_rsp_valid   (rsp_valid),
      .i_rsp_ready   (rsp_ready),
      .o_rsp_data    (rsp_data),
      .o_rsp_err     (rsp_err),
      .o_busy        (busy),
      .o_spi_cs_n    (cs_n),
      .o_spi_clock   (sclk),
      .o_spi_mosi    (mosi),
      .i_spi_miso    (miso)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   typedef struct packed {
      logic [DW-1:0] data;
      logic          err;
   } exp_t;
   exp_t sbq[$];

   // Per-frame expectations, set by the stimulus before each command.
   logic          exp_cpol = 1'b0, exp_cpha = 1'b0, exp_err = 1'b0;
   logic [1:0]    exp_cs = '0;
   logic [DW-1:0] exp_mosi = '0;
   int            exp_low = 0;
   bit            skip_mosi = 1'b0;

   // MISO source: 0 loopback, 1 slave model, 2 constant one.
   int            miso_mode = 0;
   logic          slave_miso = 1'b0;
   logic [DW-1:0] slave_byte = 8'h3C;
   assign miso = (miso_mode == 0) ? mosi : (miso_mode == 1) ? slave_miso : 1'b1;

   logic [NUM_CS-1:0] prev_cs_n = '1;
   logic              prev_sclk = 1'b0, prev_busy = 1'b0, prev_rsp_valid = 1'b0;
   logic [DW-1:0]     sl_sh = '0, sl_rx = '0;
   int                busy_cnt = 0, edge_cnt = 0, tr_len = 0, ref_len = 0;
   int                cs_low[NUM_CS];
   logic [4:0]        trace_cur[256];
   logic [4:0]        trace_ref[256];

   // Slave model and waveform monitor, sampled mid-cycle.
   always @(negedge clk) begin
      logic cs_act, cs_was, lead;
      cs_act = (cs_n != '1);
      cs_was = (prev_cs_n != '1);
      if (cs_act && !cs_was) begin
         sl_sh = slave_byte;
         sl_rx = '0;
         if (!exp_cpha) begin
            slave_miso = sl_sh[DW-1];
            sl_sh = sl_sh << 1;
         end
      end else if (cs_act && sclk != prev_sclk) begin
         lead = (sclk != exp_cpol);
         if (lead != exp_cpha) sl_rx = {sl_rx[DW-2:0], mosi};
         if (lead == exp_cpha) begin
            slave_miso = sl_sh[DW-1];
            sl_sh = sl_sh << 1;
         end
      end
      if (!cs_act && cs_was && !skip_mosi) check("slave_mosi", sl_rx, exp_mosi);

      if (busy && !prev_busy) begin
         busy_cnt = 0;
         edge_cnt = 0;
         tr_len   = 0;
         for (int k = 0; k < NUM_CS; k++) cs_low[k] = 0;
         check("lead_sclk_level", sclk, exp_cpol);
      end
      if (busy && !rsp_valid) begin
         busy_cnt++;
         if (prev_busy && sclk != prev_sclk) edge_cnt++;
         for (int k = 0; k < NUM_CS; k++) if (!cs_n[k]) cs_low[k]++;
         if (tr_len < 256) begin
            trace_cur[tr_len] = {cs_n, sclk, mosi};
            tr_len++;
         end
      end
      if (rsp_valid && !prev_rsp_valid) begin
         check("busy_cycles", busy_cnt, exp_low + GAP);
         check("sclk_edges", edge_cnt, 2 * DW);
         for (int k = 0; k < NUM_CS; k++)
            check($sformatf("cs_low_%0d", k), cs_low[k],
                  (!exp_err && k == int'(exp_cs)) ? exp_low : 0);
         check("rsp_sclk_idle", sclk, exp_cpol);
         check("rsp_mosi_last", mosi, exp_mosi[0]);
      end
      prev_cs_n      = cs_n;
      prev_sclk      = sclk;
      prev_busy      = busy;
      prev_rsp_valid = rsp_valid;
   end

   // Scoreboard: pop and compare on each response handshake.
   always @(negedge clk) begin
      exp_t e;
      if (rst_n && rsp_valid && rsp_ready) begin
         if (sbq.size() == 0) begin
            check("unexpected_rsp", 1, 0);
         end else begin
            e = sbq.pop_front();
            check("rsp_data", rsp_data, e.data);
            check("rsp_err", rsp_err, e.err);
         end
      end
   end

   task automatic send(input logic [1:0] cs, input logic cpol, input logic cpha,
                       input logic [DIVW-1:0] div, input logic [DW-1:0] data,
                       input logic [DW-1:0] rsp, input logic err, input int low,
                       input bit push);
      bit got = 1'b0;
      exp_cpol = cpol;
      exp_cpha = cpha;
      exp_cs   = cs;
      exp_err  = err;
      exp_mosi = data;
      exp_low  = low;
      if (push) sbq.push_back('{data: rsp, err: err});
      @(posedge clk); #1;
      cmd_cs    = cs;
      cmd_cpol  = cpol;
      cmd_cpha  = cpha;
      cmd_div   = div;
      cmd_data  = data;
      cmd_valid = 1'b1;
      for (int i = 0; i < 200 && !got; i++) begin
         @(negedge clk);
         if (cmd_ready) got = 1'b1;
      end
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      check("cmd_accept", got, 1);
   endtask

   task automatic wait_idle();
      bit ok = 1'b0;
      for (int i = 0; i < 2000 && !ok; i++) begin
         @(negedge clk);
         if (sbq.size() == 0 && !busy) ok = 1'b1;
      end
      check("frame_done", ok, 1);
      check("idle_mosi", mosi, 0);
      check("idle_cs_n", cs_n, 3'b111);
   endtask

   initial begin
      int  mism;
      bit  seen;
      #1 rst_n = 1'b0;
      #1;
      check("rst_cs_n", cs_n, 3'b111);
      check("rst_sclk", sclk, 0);
      check("rst_mosi", mosi, 0);
      check("rst_cmd_ready", cmd_ready, 0);
      check("rst_rsp_valid", rsp_valid, 0);
      check("rst_rsp_err", rsp_err, 0);
      check("rst_rsp_data", rsp_data, 0);
      check("rst_busy", busy, 0);
      @(posedge clk); @(posedge clk); #3 rst_n = 1'b1;
      #1 check("ready_before_edge", cmd_ready, 0);
      @(posedge clk); #1 check("ready_after_release", cmd_ready, 1);

      // Loopback frame, D=2, mode 0, target 1.
      miso_mode = 0;
      send(2'd1, 1'b0, 1'b0, 8'd2, 8'hA5, 8'hA5, 1'b0, 34, 1'b1);
      wait_idle();

      // All four clock modes against the slave model.
      miso_mode = 1;
      send(2'd0, 1'b0, 1'b0, 8'd1, 8'hC3, 8'h3C, 1'b0, 17, 1'b1);
      wait_idle();
      send(2'd2, 1'b0, 1'b1, 8'd2, 8'h5A, 8'h3C, 1'b0, 34, 1'b1);
      wait_idle();
      send(2'd1, 1'b1, 1'b0, 8'd3, 8'h81, 8'h3C, 1'b0, 51, 1'b1);
      wait_idle();
      send(2'd0, 1'b1, 1'b1, 8'd1, 8'h7E, 8'h3C, 1'b0, 17, 1'b1);
      wait_idle();

      // Divider 1 and divider 0 must produce the same waveform.
      miso_mode = 0;
      send(2'd2, 1'b1, 1'b1, 8'd1, 8'h69, 8'h69, 1'b0, 17, 1'b1);
      wait_idle();
      ref_len = tr_len;
      for (int i = 0; i < 256; i++) trace_ref[i] = trace_cur[i];
      send(2'd2, 1'b1, 1'b1, 8'd0, 8'h69, 8'h69, 1'b0, 17, 1'b1);
      wait_idle();
      check("div0_trace_len", tr_len, ref_len);
      mism = 0;
      for (int i = 0; i < ref_len && i < 256; i++) if (trace_cur[i] !== trace_ref[i]) mism++;
      check("div0_trace_diff", mism, 0);

      // Out-of-range target: no CS, normal timing, error flagged.
      miso_mode = 2;
      send(2'd3, 1'b0, 1'b0, 8'd2, 8'hC6, 8'hFF, 1'b1, 34, 1'b1);
      wait_idle();

      // Response back-pressure with a competing command held valid.
      miso_mode = 0;
      rsp_ready = 1'b0;
      send(2'd0, 1'b1, 1'b0, 8'd1, 8'h96, 8'h96, 1'b0, 17, 1'b1);
      @(posedge clk); #1;
      cmd_cs = 2'd1; cmd_data = 8'h0F; cmd_valid = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 200 && !seen; i++) begin
         @(negedge clk);
         if (rsp_valid) seen = 1'b1;
      end
      check("hold_rsp_reached", seen, 1);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check("hold_rsp_valid", rsp_valid, 1);
         check("hold_rsp_data", rsp_data, 8'h96);
         check("hold_rsp_err", rsp_err, 0);
         check("hold_cmd_ready", cmd_ready, 0);
         check("hold_cs_n", cs_n, 3'b111);
      end
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      rsp_ready = 1'b1;
      wait_idle();

      // Asynchronous reset in the middle of SHIFT.
      send(2'd1, 1'b1, 1'b0, 8'd2, 8'hF0, 8'h00, 1'b0, 34, 1'b0);
      repeat (8) @(posedge clk);
      skip_mosi = 1'b1;
      #3 rst_n = 1'b0;
      #1;
      check("mid_rst_cs_n", cs_n, 3'b111);
      check("mid_rst_sclk", sclk, 0);
      check("mid_rst_rsp_valid", rsp_valid, 0);
      check("mid_rst_busy", busy, 0);
      check("mid_rst_mosi", mosi, 0);
      check("mid_rst_cmd_ready", cmd_ready, 0);
      @(posedge clk); @(posedge clk); #3 rst_n = 1'b1;
      #1 check("mid_ready_before_edge", cmd_ready, 0);
      @(posedge clk); #1 check("mid_ready_after_release", cmd_ready, 1);
      skip_mosi = 1'b0;

      send(2'd1, 1'b0, 1'b0, 8'd2, 8'hA5, 8'hA5, 1'b0, 34, 1'b1);
      wait_idle();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached, expected test to finish");
      $fatal(1);
   end

endmodule

// File: doc/spi_multi_controller.md
SPI_MULTI_CONTROLLER -- requirements
Module: spi_multi_controller

Interface
REQ-001 SHALL have parameter NUM_CS, default 4, meaning number of chip-select lines (1..16).
REQ-002 SHALL have parameter DATA_WIDTH, default 32, meaning frame length in bits (2..64).
REQ-003 SHALL have parameter DIVIDER_WIDTH, default 8, meaning width of the per-command SCLK half-period divider.
REQ-004 SHALL have parameter GAP_CYCLES, default 2, meaning minimum CS-high cycles between frames (>=1).
REQ-005 SHALL use one clock and an asynchronous, active-low reset, with ports as follows.
- i_clock  in  1  system clock
- i_reset_n  in  1  async active-low reset
- i_cmd_valid  in  1  command offered
- o_cmd_ready  out  1  command accepted when high with i_cmd_valid
- i_cmd_cs  in  CSW=max(1,clog2(NUM_CS))  target chip-select index
- i_cmd_cpol  in  1  clock polarity
- i_cmd_cpha  in  1  clock phase
- i_cmd_divider  in  DIVIDER_WIDTH  SCLK half-period in clocks
- i_cmd_data  in  DATA_WIDTH  MOSI frame
- o_rsp_valid  out  1  response available
- i_rsp_ready  in  1  response consumed when high with o_rsp_valid
- o_rsp_data  out  DATA_WIDTH  captured MISO frame
- o_rsp_err  out  1  i_cmd_cs was >= NUM_CS
- o_busy  out  1  state is not IDLE
- o_spi_cs_n  out  NUM_CS  active-low chip selects
- o_spi_clock  out  1  SCLK
- o_spi_mosi  out  1  MOSI
- i_spi_miso  in  1  MISO

Function
REQ-006 SHALL implement FSM states IDLE, LEAD, SHIFT, TRAIL, GAP, RESP.
REQ-007 SHALL assert o_cmd_ready only in IDLE; on handshake, SHALL register cs, cpol, cpha, divider and data, then enter LEAD.
REQ-008 SHALL use effective half-period D = i_cmd_divider, with 0 treated as 1.
REQ-009 SHALL drive the selected o_spi_cs_n bit low from the first LEAD cycle until TRAIL ends; all other bits stay high.
REQ-010 SHALL hold o_spi_clock at registered cpol outside SHIFT.
REQ-011 SHALL, in SHIFT, produce 2*DATA_WIDTH SCLK edges spaced D clocks apart, the first occurring D clocks after CS falls.
REQ-012 SHALL shift MSB first.
- cpha=0: MOSI bit valid at CS fall; MISO sampled on leading edges; MOSI advanced on trailing edges.
- cpha=1: MOSI advanced on leading edges; MISO sampled on trailing edges.
REQ-013 SHALL keep CS low for exactly D*(2*DATA_WIDTH+1) cycles (LEAD D + SHIFT + TRAIL D), then deassert it.
REQ-014 SHALL hold all CS high in GAP for exactly GAP_CYCLES cycles, then enter RESP.
REQ-015 SHALL assert o_rsp_valid in RESP, with o_rsp_data and o_rsp_err stable until i_rsp_ready; on handshake SHALL return to IDLE next cycle.
REQ-016 SHALL, when i_cmd_cs >= NUM_CS, run full frame timing with no CS asserted, set o_rsp_err=1, and return o_rsp_data equal to the sampled MISO.
REQ-017 SHALL keep o_spi_mosi at the last shifted bit after SHIFT, and at 0 in IDLE.
REQ-018 SHALL ignore i_cmd_* outside IDLE; a new command SHALL never be accepted while a response is pending.

Reset
REQ-019 SHALL, on i_reset_n low (asynchronous, including mid-frame), immediately set:
- o_spi_cs_n all ones; o_spi_clock 0; o_spi_mosi 0
- o_cmd_ready 0; o_rsp_valid 0; o_rsp_err 0; o_rsp_data 0; o_busy 0
- state IDLE
REQ-020 SHALL assert o_cmd_ready on the first clock edge after reset release.

Structure
REQ-021 SHALL place state encoding, the CSW computation function and the DIVIDER=0 clamp constant in shared package spi_pkg.
REQ-022 SHALL implement the divider/edge generator as sub-module spi_clock_gen (start, D, cpol -> sclk, lead/trail edge pulses, done).

Verification
REQ-023 SHALL cover: DATA_WIDTH=8, D=2, cpol=0, cpha=0, cs=1, data 0xA5, MISO loopback -> cs_n[1] low 34 cycles, 16 SCLK edges, rsp_data 0xA5, err 0.
REQ-024 SHALL cover: each of the four cpol/cpha modes against a mode-matched slave model returning 0x3C -> rsp_data 0x3C, correct SCLK idle level.
REQ-025 SHALL cover: divider 0 versus divider 1 -> identical waveforms.
REQ-026 SHALL cover: i_cmd_cs=NUM_CS -> all cs_n high throughout, frame timing unchanged, rsp_err 1.
REQ-027 SHALL cover: i_rsp_ready held low 10 cycles with i_cmd_valid held high -> no second frame starts and rsp fields stay stable.
REQ-028 SHALL cover: reset asserted mid-SHIFT -> same-cycle cs_n all ones, sclk 0, rsp_valid 0; next command completes normally.
